// File: rtl/hazard_scoreboard_ctrl_pkg.sv
// Shared types and width helpers for the hazard/scoreboard controller.
package hazard_scoreboard_ctrl_pkg;

    // Forward-select code meaning "take the operand from the register file".
    localparam int FWD_SEL_RF = 0;

    // Width of a per-operand forward select: regfile plus one code per stage.
    function automatic int sel_width(input int num_fwd);
        return $clog2(num_fwd + 1);
    endfunction

    // Width of the outstanding-LL counter: must hold 0..max_ll inclusive.
    function automatic int cnt_width(input int max_ll);
        return $clog2(max_ll + 1);
    endfunction

    // Pipeline control bundle driven towards the pipeline top.
    typedef struct packed {
        logic if_id_exe_stall;
        logic exe_lsu_stall;
        logic id_exe_flush;
        logic exe_lsu_flush;
        logic exe_new_pc;
        logic csr_new_pc;
    } type_hzd2ptop_s;

endpackage

// File: rtl/hazard_scoreboard_ctrl_ll_scoreboard.sv
// Register scoreboard for long-latency ops: pending bits, outstanding count,
// launch acceptance and the sticky bad-completion flag.
module ll_scoreboard
    import hazard_scoreboard_ctrl_pkg::*;
#(
    parameter  int RADDR_W  = 5,
    parameter  int MAX_LL   = 4,
    localparam int NUM_REGS = 2**RADDR_W,
    localparam int CNT_W    = cnt_width(MAX_LL)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue,
    input  logic [RADDR_W-1:0]  issue_rd,
    input  logic                kill,
    input  logic                cmpl,
    input  logic [RADDR_W-1:0]  cmpl_rd,
    output logic [NUM_REGS-1:0] sb,
    output logic [CNT_W-1:0]    count,
    output logic                ack,
    output logic                err
);

    logic                full;
    logic                cmpl_hit;
    logic                issue_busy;
    logic                err_set;
    logic [NUM_REGS-1:0] sb_next;
    logic [CNT_W-1:0]    count_next;

    // Launch acceptance: room left, rd not already pending, not being flushed.
    always_comb begin
        full     = (count == CNT_W'(MAX_LL));
        cmpl_hit = cmpl & sb[cmpl_rd];
        // A completion retiring the same rd this cycle frees it for the new launch,
        // so back-to-back writers of one register keep the pipe moving.
        issue_busy = sb[issue_rd] & ~(cmpl & (cmpl_rd == issue_rd));
        ack        = issue & ~full & ~issue_busy & ~kill;
        // x0 is never pending, so a completion naming it is silently ignored.
        err_set    = cmpl & ~sb[cmpl_rd] & (cmpl_rd != '0);
    end

    // Next scoreboard/count: completion clears first, then a launch sets (launch wins).
    always_comb begin
        // NOTE: every variable gets a default before any condition, so no latch is inferred.
        sb_next    = sb;
        count_next = count;
        if (cmpl_hit) begin
            sb_next[cmpl_rd] = 1'b0;
            count_next       = count_next - CNT_W'(1);
        end
        if (ack && (issue_rd != '0)) begin
            sb_next[issue_rd] = 1'b1;
            count_next        = count_next + CNT_W'(1);
        end
    end

    // Scoreboard state with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the pending bits gate hazards directly, so unlike a data RAM they must be reset.
        if (!rst_n) begin
            sb    <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all flops updating from the same old values.
            sb    <= sb_next;
            count <= count_next;
            if (err_set) err <= 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Forwarding / stall / flush controller with long-latency scoreboard and stall watchdog.
module hazard_scoreboard_ctrl
    import hazard_scoreboard_ctrl_pkg::*;
#(
    parameter  int NUM_RS    = 2,
    parameter  int NUM_FWD   = 2,
    parameter  int RADDR_W   = 5,
    parameter  int MAX_LL    = 4,
    parameter  int STALL_TMO = 1024,
    localparam int SEL_W     = sel_width(NUM_FWD),
    localparam int CNT_W     = cnt_width(MAX_LL)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RS*RADDR_W-1:0]  exe_rs_addr_i,
    input  logic [NUM_RS-1:0]          exe_rs_use_i,
    input  logic                       exe_new_pc_req_i,
    input  logic [NUM_FWD*RADDR_W-1:0] stg_rd_addr_i,
    input  logic [NUM_FWD-1:0]         stg_rd_wr_i,
    input  logic [NUM_FWD-1:0]         stg_rd_rdy_i,
    input  logic                       ll_issue_i,
    input  logic [RADDR_W-1:0]         ll_issue_rd_i,
    input  logic                       ll_cmpl_i,
    input  logic [RADDR_W-1:0]         ll_cmpl_rd_i,
    input  logic                       csr_new_pc_req_i,
    input  logic                       csr_wfi_req_i,
    input  logic                       if_stall_i,
    output logic [NUM_RS*SEL_W-1:0]    fwd_sel_o,
    output logic                       ll_issue_ack_o,
    output logic                       if_id_exe_stall_o,
    output logic                       exe_lsu_stall_o,
    output logic                       id_exe_flush_o,
    output logic                       exe_lsu_flush_o,
    output logic                       exe_new_pc_o,
    output logic                       csr_new_pc_o,
    output logic [CNT_W-1:0]           ll_outstanding_o,
    output logic                       ll_err_o,
    output logic                       stall_tmo_o
);

    localparam int NUM_REGS = 2**RADDR_W;
    localparam int TMO_W    = (STALL_TMO > 1) ? $clog2(STALL_TMO) : 1;

    logic [NUM_REGS-1:0] sb;
    logic                use_haz;
    logic                lsu_flush;
    logic                lsu_stall;
    logic                stall;
    logic                tmo_fire;
    logic                tmo_flag;
    logic [TMO_W-1:0]    tmo_cnt;
    type_hzd2ptop_s      ctl;

    assign lsu_flush = csr_new_pc_req_i | csr_wfi_req_i;

    ll_scoreboard #(
        .RADDR_W (RADDR_W),
        .MAX_LL  (MAX_LL)
    ) u_ll_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue    (ll_issue_i),
        .issue_rd (ll_issue_rd_i),
        .kill     (lsu_flush),
        .cmpl     (ll_cmpl_i),
        .cmpl_rd  (ll_cmpl_rd_i),
        .sb       (sb),
        .count    (ll_outstanding_o),
        .ack      (ll_issue_ack_o),
        .err      (ll_err_o)
    );

    // Per-operand forward select and use hazard; the youngest matching stage decides.
    always_comb begin
        logic [RADDR_W-1:0] rs;
        logic               found;
        logic               not_rdy;
        logic [SEL_W-1:0]   sel;
        fwd_sel_o = '0;
        use_haz   = 1'b0;
        rs        = '0;
        found     = 1'b0;
        not_rdy   = 1'b0;
        sel       = SEL_W'(FWD_SEL_RF);
        for (int r = 0; r < NUM_RS; r++) begin
            rs      = exe_rs_addr_i[r*RADDR_W +: RADDR_W];
            found   = 1'b0;
            not_rdy = 1'b0;
            sel     = SEL_W'(FWD_SEL_RF);
            for (int k = 0; k < NUM_FWD; k++) begin
                if (!found && stg_rd_wr_i[k] && (rs != '0) &&
                    (stg_rd_addr_i[k*RADDR_W +: RADDR_W] == rs)) begin
                    found = 1'b1;
                    if (stg_rd_rdy_i[k]) sel = SEL_W'(k + 1);
                    else                 not_rdy = 1'b1;
                end
            end
            fwd_sel_o[r*SEL_W +: SEL_W] = sel;
            if (exe_rs_use_i[r] && (not_rdy || sb[rs])) use_haz = 1'b1;
        end
    end

    // Stall, redirect and flush decisions.
    always_comb begin
        ctl                 = '0;
        lsu_stall           = ll_issue_i & ~lsu_flush & ~ll_issue_ack_o;
        stall               = use_haz | lsu_stall | if_stall_i;
        ctl.if_id_exe_stall = stall;
        ctl.exe_lsu_stall   = lsu_stall;
        ctl.exe_new_pc      = exe_new_pc_req_i & ~stall & ~csr_new_pc_req_i;
        ctl.csr_new_pc      = csr_new_pc_req_i;
        ctl.id_exe_flush    = ctl.exe_new_pc | lsu_flush;
        ctl.exe_lsu_flush   = lsu_flush | ((use_haz | if_stall_i) & ~lsu_stall);
    end

    assign if_id_exe_stall_o = ctl.if_id_exe_stall;
    assign exe_lsu_stall_o   = ctl.exe_lsu_stall;
    assign id_exe_flush_o    = ctl.id_exe_flush;
    assign exe_lsu_flush_o   = ctl.exe_lsu_flush;
    assign exe_new_pc_o      = ctl.exe_new_pc;
    assign csr_new_pc_o      = ctl.csr_new_pc;

    // Watchdog fires in the cycle that completes STALL_TMO consecutive stalls.
    always_comb begin
        tmo_fire = (STALL_TMO != 0) && stall && (int'(tmo_cnt) == STALL_TMO - 1);
    end

    // Consecutive-stall counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else begin
            if (!stall)                    tmo_cnt <= '0;
            else if (!tmo_fire && !tmo_flag) tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_fire) tmo_flag <= 1'b1;
        end
    end

    assign stall_tmo_o = tmo_flag | tmo_fire;

endmodule
